// File: rtl/ex_mem_stage.sv
// EX->MEM elastic stage: 2-entry skid buffer toward MEM plus conditional branch resolution.
// Optional performance counters are enabled with `define EX_MEM_PERF_CNT_EN.
module ex_mem_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            zero_flag,
    input  logic            sign_flag,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            is_branch,
    input  logic [2:0]      branch_funct3,
    input  logic [XLEN-1:0] branch_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            branch_taken,
`ifdef EX_MEM_PERF_CNT_EN
    output logic [31:0]     perf_branch_taken,
    output logic [31:0]     perf_stall,
`endif
    output logic [XLEN-1:0] branch_pc
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } entry_t;

    // sign_flag is 1 for a non-negative result, so BLT is taken when it is low
    function automatic logic branch_cond(input logic [2:0] funct3,
                                         input logic zero,
                                         input logic sign);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = ~sign;
            3'b101:  taken = sign;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    logic [1:0] count_r;
    entry_t     head_r;
    entry_t     tail_r;
    entry_t     new_entry_s;
    logic       in_ready_s;
    logic       accept_s;
    logic       push_s;
    logic       pop_s;
    logic       taken_s;
    logic       branch_taken_r;
    logic [XLEN-1:0] branch_pc_r;

    // Handshake decode; flush overrides both accept and pop
    always_comb begin
        in_ready_s  = rst_n & (count_r != FULL_COUNT);
        accept_s    = in_valid & in_ready_s & ~flush;
        push_s      = accept_s & ~is_branch;
        pop_s       = (count_r != 2'd0) & out_ready & ~flush;
        taken_s     = accept_s & is_branch & branch_cond(branch_funct3, zero_flag, sign_flag);
        new_entry_s = '{result:    alu_result,
                        store:     rs2_data,
                        rd:        rd_addr,
                        reg_write: reg_write,
                        mem_read:  mem_read,
                        mem_write: mem_write};
    end

    // Skid buffer storage: head feeds MEM, tail holds the second entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            head_r  <= '0;
            tail_r  <= '0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= new_entry_s;
                    end else begin
                        tail_r <= new_entry_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                // Only reachable with one entry: the new entry replaces the departing head
                2'b11:   head_r  <= new_entry_s;
                default: count_r <= count_r;
            endcase
        end
    end

    // Branch resolution pulse; the target is held after the pulse ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_taken_r <= 1'b0;
            branch_pc_r    <= '0;
        end else begin
            branch_taken_r <= taken_s;
            if (taken_s) begin
                branch_pc_r <= branch_target;
            end
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] perf_branch_taken_r;
    logic [31:0] perf_stall_r;

    // Event counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_branch_taken_r <= 32'd0;
            perf_stall_r        <= 32'd0;
        end else begin
            if (taken_s) begin
                perf_branch_taken_r <= perf_branch_taken_r + 32'd1;
            end
            if (in_valid & ~in_ready_s) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_branch_taken = perf_branch_taken_r;
    assign perf_stall        = perf_stall_r;
`endif

    assign in_ready       = in_ready_s;
    assign out_valid      = (count_r != 2'd0);
    assign out_alu_result = head_r.result;
    assign out_store_data = head_r.store;
    assign out_rd         = head_r.rd;
    assign out_reg_write  = head_r.reg_write;
    assign out_mem_read   = head_r.mem_read;
    assign out_mem_write  = head_r.mem_write;
    assign branch_taken   = branch_taken_r;
    assign branch_pc      = branch_pc_r;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] alu_result, rs2_data, branch_target;
    logic        zero_flag, sign_flag;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_read, mem_write, is_branch;
    logic [2:0]  branch_funct3;
    logic        flush, out_valid, out_ready;
    logic [31:0] out_alu_result, out_store_data, branch_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write, branch_taken;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] perf_branch_taken, perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } ent_t;

    ent_t        q[$];
    logic        exp_bt = 1'b0;
    logic [31:0] exp_bpc = 32'd0;
    int unsigned m_bt = 0;
    int unsigned m_stall = 0;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .zero_flag(zero_flag), .sign_flag(sign_flag),
        .rs2_data(rs2_data), .rd_addr(rd_addr), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .is_branch(is_branch),
        .branch_funct3(branch_funct3), .branch_target(branch_target), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_result(out_alu_result),
        .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .branch_taken(branch_taken),
`ifdef EX_MEM_PERF_CNT_EN
        .perf_branch_taken(perf_branch_taken), .perf_stall(perf_stall),
`endif
        .branch_pc(branch_pc)
    );

    always #5 clk = ~clk;

    function automatic bit ref_taken(input logic [2:0] f3, input logic z, input logic s);
        return (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && !s) || (f3 == 3'd5 && s);
    endfunction

    task automatic set_idle();
        in_valid = 1'b0; alu_result = 32'd0; rs2_data = 32'd0; branch_target = 32'd0;
        zero_flag = 1'b0; sign_flag = 1'b0; rd_addr = 5'd0; reg_write = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; is_branch = 1'b0; branch_funct3 = 3'd0;
        flush = 1'b0; out_ready = 1'b0;
    endtask

    task automatic set_entry(input logic [31:0] res, input logic [4:0] rd);
        in_valid = 1'b1; is_branch = 1'b0; alu_result = res; rs2_data = ~res;
        rd_addr = rd; reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic z, input logic s,
                              input logic [31:0] tgt);
        in_valid = 1'b1; is_branch = 1'b1; branch_funct3 = f3;
        zero_flag = z; sign_flag = s; branch_target = tgt;
    endtask

    // One clock: model applies the rules to the inputs held across the rising edge
    task automatic cycle();
        bit acc, pop, rdy;
        ent_t e;
        rdy = rst_n && (q.size() < 2);
        acc = in_valid && rdy && !flush;
        pop = (q.size() != 0) && out_ready && !flush;
        e.res = alu_result; e.sd = rs2_data; e.rd = rd_addr;
        e.rw = reg_write; e.mr = mem_read; e.mw = mem_write;
        @(posedge clk);
        if (!rst_n) begin
            q.delete(); exp_bt = 1'b0; exp_bpc = 32'd0; m_bt = 0; m_stall = 0;
        end else begin
            if (in_valid && !rdy) m_stall++;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc && !is_branch) q.push_back(e);
            end
            exp_bt = acc && is_branch && ref_taken(branch_funct3, zero_flag, sign_flag);
            if (exp_bt) begin
                exp_bpc = branch_target;
                m_bt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        cycle(); cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || branch_taken !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: valid=%b ready=%b bt=%b, need 0 0 0",
                               out_valid, in_ready, branch_taken);
        end
        checks++;
        if (out_alu_result !== 32'd0 || out_rd !== 5'd0 || branch_pc !== 32'd0) begin
            errors++; $display("FAIL reset_data: res=%h rd=%0d pc=%h, need zeros",
                               out_alu_result, out_rd, branch_pc);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_basic();
        set_idle();
        out_ready = 1'b1;
        set_entry(32'h1234, 5'd5);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_alu_result !== 32'h1234 || out_rd !== 5'd5 ||
            out_reg_write !== 1'b1 || out_store_data !== ~32'h1234) begin
            errors++; $display("FAIL basic_head: v=%b res=%h rd=%0d rw=%b sd=%h, need 1 1234 5 1 %h",
                               out_valid, out_alu_result, out_rd, out_reg_write, out_store_data, ~32'h1234);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain: out_valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_seq [3];
        logic [31:0] seen;
        exp_seq[0] = 32'hA; exp_seq[1] = 32'hB; exp_seq[2] = 32'hC;
        set_idle();
        set_entry(32'hA, 5'd1); cycle();
        checks++;
        if (in_ready !== 1'b1 || out_alu_result !== 32'hA) begin
            errors++; $display("FAIL bp_first: ready=%b head=%h need 1 a", in_ready, out_alu_result);
        end
        set_entry(32'hB, 5'd2); cycle();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full_ready: got %b need 0", in_ready);
        end
        set_entry(32'hC, 5'd3); cycle();
        checks++;
        if (in_ready !== 1'b0 || out_alu_result !== 32'hA || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: ready=%b v=%b head=%h need 0 1 a",
                               in_ready, out_valid, out_alu_result);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            seen = out_alu_result;
            checks++;
            if (out_valid !== 1'b1 || seen !== exp_seq[i]) begin
                errors++; $display("FAIL bp_order[%0d]: v=%b head=%h need 1 %h",
                                   i, out_valid, seen, exp_seq[i]);
            end
            cycle();
            if (i == 1) in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty: out_valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_branch();
        set_idle();
        out_ready = 1'b1;
        set_branch(3'b000, 1'b1, 1'b0, 32'h80);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (branch_taken !== 1'b1 || branch_pc !== 32'h80 || out_valid !== 1'b0) begin
            errors++; $display("FAIL br_beq: bt=%b pc=%h v=%b need 1 80 0",
                               branch_taken, branch_pc, out_valid);
        end
        cycle();
        checks++;
        if (branch_taken !== 1'b0 || branch_pc !== 32'h80) begin
            errors++; $display("FAIL br_pulse_end: bt=%b pc=%h need 0 80", branch_taken, branch_pc);
        end
        set_branch(3'b100, 1'b0, 1'b1, 32'h100);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (branch_taken !== 1'b0 || branch_pc !== 32'h80 || out_valid !== 1'b0) begin
            errors++; $display("FAIL br_blt_not: bt=%b pc=%h v=%b need 0 80 0",
                               branch_taken, branch_pc, out_valid);
        end
    endtask

    task automatic test_flush();
        set_idle();
        set_entry(32'h11, 5'd1); cycle();
        set_entry(32'h22, 5'd2); cycle();
        set_branch(3'b001, 1'b0, 1'b0, 32'h200);
        flush = 1'b1;
        cycle();
        set_idle();
        checks++;
        if (out_valid !== 1'b0 || branch_taken !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full: v=%b bt=%b ready=%b need 0 0 1",
                               out_valid, branch_taken, in_ready);
        end
        set_entry(32'h33, 5'd3); cycle();
        set_branch(3'b000, 1'b1, 1'b0, 32'h300);
        flush = 1'b1; out_ready = 1'b1;
        cycle();
        set_idle();
        checks++;
        if (out_valid !== 1'b0 || branch_taken !== 1'b0 || branch_pc !== 32'h80) begin
            errors++; $display("FAIL flush_branch: v=%b bt=%b pc=%h need 0 0 80",
                               out_valid, branch_taken, branch_pc);
        end
    endtask

    task automatic test_midop_reset();
        set_idle();
        set_entry(32'h44, 5'd4); cycle();
        set_entry(32'h55, 5'd5); cycle();
        set_idle();
        rst_n = 1'b0;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_alu_result !== 32'd0 ||
            out_rd !== 5'd0 || branch_pc !== 32'd0) begin
            errors++; $display("FAIL midreset: v=%b ready=%b res=%h rd=%0d pc=%h need zeros",
                               out_valid, in_ready, out_alu_result, out_rd, branch_pc);
        end
        rst_n = 1'b1;
        set_entry(32'h66, 5'd6); cycle();
        set_idle();
        checks++;
        if (out_valid !== 1'b1 || out_alu_result !== 32'h66 || out_rd !== 5'd6) begin
            errors++; $display("FAIL midreset_resume: v=%b res=%h rd=%0d need 1 66 6",
                               out_valid, out_alu_result, out_rd);
        end
    endtask

`ifdef EX_MEM_PERF_CNT_EN
    task automatic test_perf();
        set_idle();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_branch(3'b101, 1'b0, 1'b1, 32'h400 + 32'(i)); cycle();
        end
        set_idle();
        set_entry(32'h77, 5'd7); cycle();
        set_entry(32'h88, 5'd8); cycle();
        for (int i = 0; i < 4; i++) cycle();
        set_idle();
        checks++;
        if (perf_branch_taken !== 32'd3 || perf_stall !== 32'd4) begin
            errors++; $display("FAIL perf_counts: bt=%0d stall=%0d need 3 4",
                               perf_branch_taken, perf_stall);
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rnd_ctrl[%0d]: v=%b ready=%b need %b %b", n,
                                   out_valid, in_ready, q.size() != 0, q.size() < 2);
            end
            if (q.size() != 0) begin
                checks++;
                if (out_alu_result !== q[0].res || out_store_data !== q[0].sd || out_rd !== q[0].rd ||
                    out_reg_write !== q[0].rw || out_mem_read !== q[0].mr || out_mem_write !== q[0].mw) begin
                    errors++; $display("FAIL rnd_head[%0d]: res=%h sd=%h rd=%0d need %h %h %0d", n,
                                       out_alu_result, out_store_data, out_rd, q[0].res, q[0].sd, q[0].rd);
                end
            end
            checks++;
            if (branch_taken !== exp_bt || branch_pc !== exp_bpc) begin
                errors++; $display("FAIL rnd_branch[%0d]: bt=%b pc=%h need %b %h", n,
                                   branch_taken, branch_pc, exp_bt, exp_bpc);
            end
`ifdef EX_MEM_PERF_CNT_EN
            checks++;
            if (perf_branch_taken !== m_bt || perf_stall !== m_stall) begin
                errors++; $display("FAIL rnd_perf[%0d]: bt=%0d stall=%0d need %0d %0d", n,
                                   perf_branch_taken, perf_stall, m_bt, m_stall);
            end
`endif
            in_valid      = ($urandom_range(0, 9) < 7);
            out_ready     = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 19) == 0);
            is_branch     = ($urandom_range(0, 3) == 0);
            branch_funct3 = 3'($urandom);
            zero_flag     = 1'($urandom);
            sign_flag     = 1'($urandom);
            alu_result    = $urandom;
            rs2_data      = $urandom;
            branch_target = $urandom;
            rd_addr       = 5'($urandom);
            reg_write     = 1'($urandom);
            mem_read      = 1'($urandom);
            mem_write     = 1'($urandom);
            cycle();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_branch();
        test_flush();
        test_midop_reset();
`ifdef EX_MEM_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
